// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared width helpers and parameter range checks for the FWFT FIFO
package fifo_pkg;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 4) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit afull_ok(input int depth, input int afull);
    return (afull >= 1) && (afull <= depth);
  endfunction

  function automatic bit aempty_ok(input int depth, input int aempty);
    return (aempty >= 0) && (aempty <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - simple dual-port RAM, registered read, no reset so it maps to block RAM
module sync_fifo_mem
  import fifo_pkg::*;
#(
  parameter int P_DEPTH = 1024,
  parameter int P_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        wr_en,
  input  logic [ptr_w(P_DEPTH)-1:0]   wr_addr,
  input  logic [P_WIDTH-1:0]          wr_data,
  input  logic                        rd_en,
  input  logic [ptr_w(P_DEPTH)-1:0]   rd_addr,
  output logic [P_WIDTH-1:0]          rd_data
);

  logic [P_WIDTH-1:0] mem [P_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - single-clock first-word-fall-through FIFO with a two-stage read prefetch
module sync_fifo_fwft
  import fifo_pkg::*;
#(
  parameter int P_DEPTH  = 1024,
  parameter int P_WIDTH  = 8,
  parameter int P_AFULL  = P_DEPTH - 4,
  parameter int P_AEMPTY = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic [P_WIDTH-1:0]          wr_data,
  input  logic                        wr_vld,
  output logic                        wr_rdy,
  output logic [P_WIDTH-1:0]          rd_data,
  output logic                        rd_vld,
  input  logic                        rd_rdy,
  output logic [cnt_w(P_DEPTH)-1:0]   count,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic                        overflow
);

  localparam int AW = ptr_w(P_DEPTH);
  localparam int CW = cnt_w(P_DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(P_DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(P_AFULL);
  localparam logic [CW-1:0] AEMPTY_C = CW'(P_AEMPTY);

  if (!depth_ok(P_DEPTH)) begin : g_bad_depth
    $error("sync_fifo_fwft: P_DEPTH must be a power of 2 and >= 4");
  end
  if (!afull_ok(P_DEPTH, P_AFULL)) begin : g_bad_afull
    $error("sync_fifo_fwft: P_AFULL out of range 1..P_DEPTH");
  end
  if (!aempty_ok(P_DEPTH, P_AEMPTY)) begin : g_bad_aempty
    $error("sync_fifo_fwft: P_AEMPTY out of range 0..P_DEPTH-1");
  end

  // Pointers carry one extra wrap bit so equal pointers unambiguously mean the RAM is empty.
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               stage_vld;
  logic [P_WIDTH-1:0] mem_q;
  logic               wr_en;
  logic               pop;
  logic               mem_empty;
  logic               out_ready;
  logic               stage_ready;
  logic               mem_rd;

  assign wr_rdy       = count < DEPTH_C;
  assign wr_en        = wr_vld && wr_rdy && !flush;
  assign pop          = rd_vld && rd_rdy && !flush;
  assign mem_empty    = wr_ptr == rd_ptr;
  assign out_ready    = !rd_vld || rd_rdy;
  assign stage_ready  = !stage_vld || out_ready;
  assign mem_rd       = !mem_empty && stage_ready && !flush;
  assign almost_full  = count >= AFULL_C;
  assign almost_empty = count <= AEMPTY_C;

  sync_fifo_mem #(
    .P_DEPTH (P_DEPTH),
    .P_WIDTH (P_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (wr_data),
    .rd_en   (mem_rd),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (mem_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + (AW+1)'(1);
      if (mem_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // count spans RAM, read register and output stage, so the RAM can never be over-filled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (wr_en && !pop) begin
      count <= count + CW'(1);
    end else if (pop && !wr_en) begin
      count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (flush) begin
      overflow <= 1'b0;
    end else if (wr_vld && !wr_rdy) begin
      overflow <= 1'b1;
    end
  end

  // RAM read register feeds the output stage; both advance only when the next stage frees up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_vld <= 1'b0;
      rd_vld    <= 1'b0;
      rd_data   <= '0;
    end else if (flush) begin
      stage_vld <= 1'b0;
      rd_vld    <= 1'b0;
    end else begin
      if (mem_rd) begin
        stage_vld <= 1'b1;
      end else if (out_ready) begin
        stage_vld <= 1'b0;
      end
      if (out_ready) begin
        rd_vld <= stage_vld;
        if (stage_vld) rd_data <= mem_q;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// tb/tb_sync_fifo_fwft.sv - self-checking bench for sync_fifo_fwft at P_DEPTH=16
module tb_sync_fifo_fwft;

  localparam int DEPTH      = 16;
  localparam int STREAM_CNT = 3;  // write edge, two prefetch edges, pop edge

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [7:0] wr_data;
  logic       wr_vld;
  logic       wr_rdy;
  logic [7:0] rd_data;
  logic       rd_vld;
  logic       rd_rdy;
  logic [4:0] count;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;

  sync_fifo_fwft #(
    .P_DEPTH (DEPTH),
    .P_WIDTH (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .wr_data      (wr_data),
    .wr_vld       (wr_vld),
    .wr_rdy       (wr_rdy),
    .rd_data      (rd_data),
    .rd_vld       (rd_vld),
    .rd_rdy       (rd_rdy),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr_vld;
    logic [7:0] wr_data;
    logic       rd_rdy;
    logic       flush;
    int         e_count;
    logic       e_wr_rdy;
    logic       e_afull;
    logic       e_aempty;
    logic       e_ovf;
    logic       e_rd_vld;
    logic       chk_data;
    logic [7:0] e_rd_data;
  } vec_t;

  vec_t       vecs[21];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] sb[$];
  int         exp_cnt = 0;
  logic       exp_ovf = 1'b0;
  int         n_push = 0;
  logic       p_ok = 1'b0;
  logic       p_vld = 1'b0;
  logic       p_rdy = 1'b0;
  logic [7:0] p_data = 8'h00;

  function automatic vec_t mk(input logic wv, input logic [7:0] wd, input logic rr, input logic fl,
                              input int ec, input logic ewr, input logic eaf, input logic eae,
                              input logic eov, input logic erv, input logic cd, input logic [7:0] erd);
    vec_t v;
    v.wr_vld = wv;  v.wr_data = wd;  v.rd_rdy = rr;  v.flush = fl;
    v.e_count = ec; v.e_wr_rdy = ewr; v.e_afull = eaf; v.e_aempty = eae;
    v.e_ovf = eov;  v.e_rd_vld = erv; v.chk_data = cd; v.e_rd_data = erd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model and scoreboard, evaluated on the falling edge ahead of each rising edge.
  task automatic monitor();
    logic [7:0] head;
    logic       do_push;
    logic       do_pop;
    if (!rst_n) begin
      sb.delete();
      exp_cnt = 0;
      exp_ovf = 1'b0;
      p_ok    = 1'b0;
    end else begin
      chk("count", 32'(count), exp_cnt);
      chk("wr_rdy", 32'(wr_rdy), 32'(exp_cnt < DEPTH));
      chk("almost_full", 32'(almost_full), 32'(exp_cnt >= DEPTH - 4));
      chk("almost_empty", 32'(almost_empty), 32'(exp_cnt <= 4));
      chk("overflow", 32'(overflow), 32'(exp_ovf));
      if (p_ok && p_vld && !p_rdy) begin
        chk("hold_vld", 32'(rd_vld), 32'(1));
        chk("hold_data", 32'(rd_data), 32'(p_data));
      end
      if (p_ok && !p_vld && !rd_vld) chk("idle_data", 32'(rd_data), 32'(p_data));
      if (flush) begin
        sb.delete();
        exp_cnt = 0;
        exp_ovf = 1'b0;
        p_ok    = 1'b0;
      end else begin
        do_push = wr_vld && (exp_cnt < DEPTH);
        do_pop  = rd_vld && rd_rdy;
        if (wr_vld && exp_cnt == DEPTH) exp_ovf = 1'b1;
        if (do_pop) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_underflow: got pop of 0x%0h expected no word at t=%0t", rd_data, $time);
          end else begin
            head = sb.pop_front();
            chk("sb_rd_data", 32'(rd_data), 32'(head));
          end
        end
        if (do_push) begin
          sb.push_back(wr_data);
          n_push++;
        end
        exp_cnt = exp_cnt + int'(do_push) - int'(do_pop);
        p_ok   = 1'b1;
        p_vld  = rd_vld;
        p_rdy  = rd_rdy;
        p_data = rd_data;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_wr_rdy"}, 32'(wr_rdy), 32'(1));
    chk({tag, "_rd_vld"}, 32'(rd_vld), 32'(0));
    chk({tag, "_count"}, 32'(count), 32'(0));
    chk({tag, "_aempty"}, 32'(almost_empty), 32'(1));
    chk({tag, "_afull"}, 32'(almost_full), 32'(0));
    chk({tag, "_ovf"}, 32'(overflow), 32'(0));
  endtask

  task automatic drain(input string tag, input int budget);
    wr_vld = 1'b0;
    rd_rdy = 1'b1;
    for (int k = 0; k < budget && count != 5'd0; k++) tick();
    chk({tag, "_drain_count"}, 32'(count), 32'(0));
    chk({tag, "_drain_sb"}, sb.size(), 32'(0));
    rd_rdy = 1'b0;
  endtask

  task automatic wait_vld(input string tag, input int budget);
    for (int k = 0; k < budget && !rd_vld; k++) tick();
    chk({tag, "_vld"}, 32'(rd_vld), 32'(1));
  endtask

  initial begin
    for (int i = 0; i < 16; i++)
      vecs[i] = mk(1'b1, 8'(i + 1), 1'b0, 1'b0, i + 1, (i + 1) < 16, (i + 1) >= 12, (i + 1) <= 4,
                   1'b0, i >= 2, i >= 2, 8'h01);
    vecs[16] = mk(1'b1, 8'h11, 1'b0, 1'b0, 16, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01);
    vecs[17] = mk(1'b0, 8'h00, 1'b1, 1'b0, 15, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h02);
    vecs[18] = mk(1'b1, 8'h12, 1'b1, 1'b0, 15, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h03);
    vecs[19] = mk(1'b1, 8'h13, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    vecs[20] = mk(1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

    rst_n = 1'b0; flush = 1'b0; wr_vld = 1'b0; rd_rdy = 1'b0; wr_data = 8'h00;
    repeat (3) tick();
    check_reset("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      wr_vld = vecs[i].wr_vld; wr_data = vecs[i].wr_data;
      rd_rdy = vecs[i].rd_rdy; flush = vecs[i].flush;
      tick();
      chk($sformatf("vec%0d_count", i), 32'(count), vecs[i].e_count);
      chk($sformatf("vec%0d_wr_rdy", i), 32'(wr_rdy), 32'(vecs[i].e_wr_rdy));
      chk($sformatf("vec%0d_afull", i), 32'(almost_full), 32'(vecs[i].e_afull));
      chk($sformatf("vec%0d_aempty", i), 32'(almost_empty), 32'(vecs[i].e_aempty));
      chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].e_ovf));
      chk($sformatf("vec%0d_rd_vld", i), 32'(rd_vld), 32'(vecs[i].e_rd_vld));
      if (vecs[i].chk_data)
        chk($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].e_rd_data));
    end
    wr_vld = 1'b0; rd_rdy = 1'b0; flush = 1'b0;

    // Single word latency from empty
    wr_vld = 1'b1; wr_data = 8'hA5;
    tick();
    chk("lat_n0_vld", 32'(rd_vld), 32'(0));
    wr_vld = 1'b0;
    tick();
    chk("lat_n1_vld", 32'(rd_vld), 32'(0));
    tick();
    chk("lat_n2_vld", 32'(rd_vld), 32'(1));
    chk("lat_n2_data", 32'(rd_data), 32'hA5);
    rd_rdy = 1'b1;
    tick();
    rd_rdy = 1'b0;
    chk("lat_pop_count", 32'(count), 32'(0));
    chk("lat_pop_vld", 32'(rd_vld), 32'(0));

    // Continuous streaming
    wr_vld = 1'b1; rd_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      wr_data = 8'(i);
      tick();
      if (i >= 2) begin
        chk("stream_vld", 32'(rd_vld), 32'(1));
        chk("stream_count", 32'(count), STREAM_CNT);
      end
    end
    drain("stream", 20);

    // Random traffic across at least ten pointer wraps
    begin
      int start;
      int cyc;
      start = n_push;
      cyc = 0;
      while ((n_push - start) < 10 * DEPTH + 10 && cyc < 3000) begin
        wr_vld  = ($urandom_range(0, 99) < 55);
        rd_rdy  = ($urandom_range(0, 99) < 50);
        wr_data = 8'($urandom);
        tick();
        cyc++;
      end
      chk("random_wraps", 32'((n_push - start) >= 10 * DEPTH + 10), 32'(1));
    end
    drain("random", 40);

    // Flush at count 9 with a simultaneous write
    rd_rdy = 1'b0; wr_vld = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wr_data = 8'(8'h40 + i);
      tick();
    end
    chk("flush_pre_count", 32'(count), 32'(9));
    flush = 1'b1; wr_data = 8'h77;
    tick();
    flush = 1'b0; wr_vld = 1'b0;
    chk("flush_count", 32'(count), 32'(0));
    chk("flush_vld", 32'(rd_vld), 32'(0));
    chk("flush_ovf", 32'(overflow), 32'(0));
    wr_vld = 1'b1; wr_data = 8'h5C;
    tick();
    wr_vld = 1'b0;
    wait_vld("flush_next", 5);
    chk("flush_next_data", 32'(rd_data), 32'h5C);
    drain("flush", 10);

    // Asynchronous reset between clock edges while streaming
    wr_vld = 1'b1; rd_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_data = 8'(8'hC0 + i);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async");
    wr_vld = 1'b0; rd_rdy = 1'b0;
    tick();
    tick();
    rst_n = 1'b1; wr_vld = 1'b1; wr_data = 8'h3C;
    tick();
    wr_vld = 1'b0;
    chk("post_reset_count", 32'(count), 32'(1));
    wait_vld("post_reset", 5);
    chk("post_reset_data", 32'(rd_data), 32'h3C);
    drain("post_reset", 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected finish", $time);
    $fatal(1);
  end

endmodule
